// File: rtl/cfg_regfile.sv
// cfg_regfile: configuration register file with RW control registers,
// RO status registers, a W1C sticky event register and interrupt output.
// Optional macro CFG_SHADOW_EN: control writes land in shadow registers and
// take effect together on a write to COMMIT_ADDR.
module cfg_regfile #(
  parameter int unsigned CFG_DATA_WIDTH = 32,
  parameter int unsigned CFG_ADDR_WIDTH = 5,
  parameter int          NUM_RW         = 16,
  parameter int          NUM_RO         = 8
) (
  input  logic                             axi_clk,
  input  logic                             axi_rst_n,
  input  logic [CFG_DATA_WIDTH-1:0]        cfg_wr_data,
  input  logic [CFG_ADDR_WIDTH-1:0]        cfg_wr_addr,
  input  logic                             cfg_wr_en,
  input  logic [CFG_ADDR_WIDTH-1:0]        cfg_rd_addr,
  input  logic                             cfg_rd_en,
  output logic [CFG_DATA_WIDTH-1:0]        cfg_rd_data,
  output logic [NUM_RW*CFG_DATA_WIDTH-1:0] cfg_reg,
  output logic [NUM_RW-1:0]                cfg_reg_en,
  input  logic [NUM_RO*CFG_DATA_WIDTH-1:0] sts_in,
  input  logic [CFG_DATA_WIDTH-1:0]        evt_in,
  output logic                             irq
);

  localparam int unsigned W           = CFG_DATA_WIDTH;
  localparam int unsigned AW          = CFG_ADDR_WIDTH;
  localparam int          EVT_ADDR    = NUM_RW + NUM_RO;
  localparam int          COMMIT_ADDR = EVT_ADDR + 1;

  // Reject address maps that do not fit or have no control registers
  if ((longint'(NUM_RW) + longint'(NUM_RO) + 64'sd2 > (longint'(1) << AW)) ||
      (NUM_RW < 1) || (NUM_RO < 0)) begin : g_bad_params
    $error("cfg_regfile: illegal NUM_RW/NUM_RO/CFG_ADDR_WIDTH combination");
  end

  // Stored control values (the shadow copy when double-buffering)
  logic [W-1:0]      ctrl_q [NUM_RW];
  logic [W-1:0]      sticky_q;
  logic [NUM_RW-1:0] wr_sel_c;
  logic              wr_evt_c;
  logic [W-1:0]      rd_mux_c;

  // Write address decode
  always_comb begin
    wr_sel_c = '0;
    wr_evt_c = 1'b0;
    if (cfg_wr_en) begin
      for (int k = 0; k < NUM_RW; k++) begin
        if (cfg_wr_addr == AW'(k)) wr_sel_c[k] = 1'b1;
      end
      wr_evt_c = (cfg_wr_addr == AW'(EVT_ADDR));
    end
  end

  // Read mux over pre-write state; unmapped and commit addresses read as 0
  always_comb begin
    rd_mux_c = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (cfg_rd_addr == AW'(k)) rd_mux_c = ctrl_q[k];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (cfg_rd_addr == AW'(NUM_RW + j)) rd_mux_c = sts_in[j*W +: W];
    end
    if (cfg_rd_addr == AW'(EVT_ADDR)) rd_mux_c = sticky_q;
  end

  // Control storage, sticky events (set beats clear), read data and irq
  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) begin
      for (int k = 0; k < NUM_RW; k++) ctrl_q[k] <= '0;
      sticky_q    <= '0;
      cfg_rd_data <= '0;
      irq         <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_RW; k++) begin
        if (wr_sel_c[k]) ctrl_q[k] <= cfg_wr_data;
      end
      sticky_q    <= (sticky_q & ~(wr_evt_c ? cfg_wr_data : W'(0))) | evt_in;
      cfg_rd_data <= cfg_rd_en ? rd_mux_c : W'(0);
      irq         <= |sticky_q;
    end
  end

`ifdef CFG_SHADOW_EN

  logic [W-1:0]      active_q [NUM_RW];
  logic [NUM_RW-1:0] dirty_q;
  logic              wr_commit_c;

  // Commit strobe decode
  always_comb begin
    wr_commit_c = cfg_wr_en && (cfg_wr_addr == AW'(COMMIT_ADDR));
  end

  // Commit copies every shadow, pulses only the registers written since
  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) begin
      for (int k = 0; k < NUM_RW; k++) active_q[k] <= '0;
      dirty_q    <= '0;
      cfg_reg_en <= '0;
    end else if (wr_commit_c) begin
      for (int k = 0; k < NUM_RW; k++) active_q[k] <= ctrl_q[k];
      dirty_q    <= '0;
      cfg_reg_en <= dirty_q;
    end else begin
      dirty_q    <= dirty_q | wr_sel_c;
      cfg_reg_en <= '0;
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_cfg_out
    assign cfg_reg[k*W +: W] = active_q[k];
  end

`else

  // Update pulse lines up with the first cycle the new value is visible
  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) begin
      cfg_reg_en <= '0;
    end else begin
      cfg_reg_en <= wr_sel_c;
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_cfg_out
    assign cfg_reg[k*W +: W] = ctrl_q[k];
  end

`endif

endmodule

// File: doc/cfg_regfile.md
CFG_REGFILE -- requirements
Module: cfg_regfile

Interface
REQ-001 Parameter CFG_DATA_WIDTH, default 32, width of every register and data port.
REQ-002 Parameter CFG_ADDR_WIDTH, default 5, width of cfg_wr_addr and cfg_rd_addr.
REQ-003 Parameter NUM_RW, default 16, count of read/write control registers.
REQ-004 Parameter NUM_RO, default 8, count of read-only status registers.
REQ-005 Port axi_clk  in  1  single clock; all logic on rising edge.
REQ-006 Port axi_rst_n  in  1  reset, synchronous, active-low.
REQ-007 Port cfg_wr_data  in  CFG_DATA_WIDTH  write data, qualified by cfg_wr_en.
REQ-008 Port cfg_wr_addr  in  CFG_ADDR_WIDTH  write word address.
REQ-009 Port cfg_wr_en  in  1  one-cycle write strobe.
REQ-010 Port cfg_rd_addr  in  CFG_ADDR_WIDTH  read word address.
REQ-011 Port cfg_rd_en  in  1  one-cycle read strobe.
REQ-012 Port cfg_rd_data  out  CFG_DATA_WIDTH  registered read data.
REQ-013 Port cfg_reg  out  NUM_RW*CFG_DATA_WIDTH  active control values, register k at bits [k*W +: W].
REQ-014 Port cfg_reg_en  out  NUM_RW  per-register one-cycle update pulse.
REQ-015 Port sts_in  in  NUM_RO*CFG_DATA_WIDTH  status words, status j at bits [j*W +: W].
REQ-016 Port evt_in  in  CFG_DATA_WIDTH  event pulses, one per bit.
REQ-017 Port irq  out  1  high while any sticky event bit is set.

Function
REQ-018 Address map SHALL be: 0..NUM_RW-1 control (RW); NUM_RW..NUM_RW+NUM_RO-1 status (RO); EVT_ADDR=NUM_RW+NUM_RO sticky events (W1C); COMMIT_ADDR=EVT_ADDR+1; all others unmapped.
REQ-019 Elaboration SHALL fail if NUM_RW+NUM_RO+2 > 2**CFG_ADDR_WIDTH or NUM_RW < 1 or NUM_RO < 0.
REQ-020 Write to control k SHALL store cfg_wr_data into register k on the following edge.
REQ-021 Writes to status, unmapped, or (macro absent) COMMIT_ADDR SHALL be ignored with no side effect.
REQ-022 cfg_rd_data SHALL be valid exactly one cycle after cfg_rd_en and SHALL be 0 in every cycle not following cfg_rd_en.
REQ-023 Read of control k SHALL return its stored value; read of status j SHALL return sts_in word j sampled at the cfg_rd_en edge; unmapped and COMMIT_ADDR reads SHALL return 0.
REQ-024 Read and write to the same address in the same cycle SHALL return the pre-write value.
REQ-025 Each evt_in bit high SHALL set the matching sticky bit on the next edge; read of EVT_ADDR SHALL return sticky bits.
REQ-026 Write to EVT_ADDR SHALL clear bits where cfg_wr_data is 1; a same-cycle evt_in set SHALL win over clear.
REQ-027 irq SHALL be registered: irq = OR of sticky bits, one cycle after bits change.
REQ-028 cfg_reg_en[k] SHALL pulse high for exactly one cycle, coincident with the first cycle cfg_reg shows the new value of register k.

Reset
REQ-029 With axi_rst_n low at an edge: all control registers, shadows, dirty bits, sticky bits, cfg_rd_data, cfg_reg_en, irq SHALL become 0.
REQ-030 Reset SHALL override any same-cycle write, read, or event; a read issued in the reset cycle SHALL return 0.

Configuration
REQ-031 Macro CFG_SHADOW_EN SHALL select double-buffered commit mode.
REQ-032 Absent: cfg_reg SHALL equal stored control values directly; cfg_reg_en[k] pulses one cycle after each write to k.
REQ-033 Present: writes SHALL land in shadow register k and set dirty bit k; cfg_reg SHALL remain unchanged; reads SHALL return shadow values.
REQ-034 Present: a write to COMMIT_ADDR (data ignored) SHALL copy all shadows into cfg_reg on the next edge, pulse cfg_reg_en for dirty registers only, and clear all dirty bits.
REQ-035 Present: a commit with no dirty bits SHALL produce no cfg_reg_en pulse.

Verification
REQ-036 Reset, then write 0xDEADBEEF to addr 3 -> next cycle cfg_reg word 3 = 0xDEADBEEF, cfg_reg_en = 0x0008 for one cycle (macro absent).
REQ-037 sts_in word 2 = 0x12345678, read addr 18 -> cfg_rd_data = 0x12345678 one cycle later, then 0.
REQ-038 evt_in = 0x5 one cycle -> irq high; write 0x4 to EVT_ADDR simultaneous with evt_in = 0x4 -> sticky reads 0x5; write 0x5 -> sticky 0, irq low.
REQ-039 Macro present: write 0xA to addr 1, 0xB to addr 2 -> cfg_reg unchanged, readback 0xA/0xB; write COMMIT_ADDR -> both update same cycle, cfg_reg_en = 0x0006.
REQ-040 Read addr 31 and write addr 31 -> cfg_rd_data 0, no state change; assert axi_rst_n low mid-sequence -> all outputs 0 next cycle.
